// File: rtl/gon_xbus_ctrl.sv
// GON X-bus sequencer: serially loads column IDs into the MCC scan chain, then runs
// tagged transfers one at a time. Optional transfer timeout under `GON_XBUS_TIMEOUT_EN.
module gon_xbus_ctrl #(
  parameter int unsigned COL_TAG_WIDTH  = 4,
  parameter int unsigned NUM_OF_COLS    = 14,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cfg_start,
  input  logic [NUM_OF_COLS*COL_TAG_WIDTH-1:0]   cfg_ids,
  output logic                                   cfg_busy,
  output logic                                   cfg_done,
  output logic                                   configured,
  output logic                                   scan_en_id,
  output logic                                   scan_out_id,
  input  logic                                   req_valid,
  input  logic [COL_TAG_WIDTH-1:0]               req_tag,
  output logic                                   req_ready,
  output logic [COL_TAG_WIDTH-1:0]               col_tag,
  output logic                                   enable_in,
  input  logic [NUM_OF_COLS-1:0]                 bus_ready,
  output logic                                   xfer_done,
  output logic                                   xfer_err
);

  localparam int unsigned SCAN_LEN = NUM_OF_COLS * COL_TAG_WIDTH;
  localparam int unsigned CNT_W    = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;

  localparam logic [1:0] ST_UNCFG = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;
  localparam logic [1:0] ST_XFER  = 2'd3;

  logic [1:0]               r_state,      w_state_d;
  logic [SCAN_LEN-1:0]      r_shadow,     w_shadow_d;
  logic [CNT_W-1:0]         r_cnt,        w_cnt_d;
  logic                     r_configured, w_configured_d;
  logic                     r_cfg_done,   w_cfg_done_d;
  logic [COL_TAG_WIDTH-1:0] r_col_tag,    w_col_tag_d;
  logic                     r_xfer_done,  w_xfer_done_d;
  logic                     r_xfer_err,   w_xfer_err_d;
  logic                     r_shift;
  logic                     r_scan_out;
  logic                     r_enable;
  logic                     w_req_ready;
  logic                     w_any_ready;

`ifdef GON_XBUS_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_d;
`endif

  // Config always wins over a same-cycle request.
  assign w_req_ready = (r_state == ST_IDLE) && !cfg_start;
  assign w_any_ready = |bus_ready;

  always_comb begin
    w_state_d      = r_state;
    w_shadow_d     = r_shadow;
    w_cnt_d        = r_cnt;
    w_configured_d = r_configured;
    w_cfg_done_d   = 1'b0;
    w_col_tag_d    = r_col_tag;
    w_xfer_done_d  = 1'b0;
    w_xfer_err_d   = 1'b0;
`ifdef GON_XBUS_TIMEOUT_EN
    w_to_cnt_d     = r_to_cnt;
`endif
    case (r_state)
      ST_UNCFG, ST_IDLE: begin
        if (cfg_start) begin
          w_shadow_d     = cfg_ids;
          w_cnt_d        = CNT_W'(SCAN_LEN - 1);
          w_configured_d = 1'b0;
          w_state_d      = ST_SHIFT;
        end else if (w_req_ready && req_valid) begin
          w_col_tag_d = req_tag;
          w_state_d   = ST_XFER;
`ifdef GON_XBUS_TIMEOUT_EN
          w_to_cnt_d  = '0;
`endif
        end
      end
      ST_SHIFT: begin
        w_shadow_d = r_shadow << 1;
        if (r_cnt == '0) begin
          w_state_d      = ST_IDLE;
          w_cfg_done_d   = 1'b1;
          w_configured_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      ST_XFER: begin
        if (w_any_ready) begin
          w_state_d     = ST_IDLE;
          w_xfer_done_d = 1'b1;
        end
`ifdef GON_XBUS_TIMEOUT_EN
        // Ready in the final allowed cycle still counts as success (checked above).
        else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_d    = ST_IDLE;
          w_xfer_err_d = 1'b1;
        end else begin
          w_to_cnt_d = r_to_cnt + 1'b1;
        end
`endif
      end
      default: w_state_d = ST_UNCFG;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_UNCFG;
      r_shadow     <= '0;
      r_cnt        <= '0;
      r_configured <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_col_tag    <= '0;
      r_xfer_done  <= 1'b0;
      r_xfer_err   <= 1'b0;
      r_shift      <= 1'b0;
      r_scan_out   <= 1'b0;
      r_enable     <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_shadow     <= w_shadow_d;
      r_cnt        <= w_cnt_d;
      r_configured <= w_configured_d;
      r_cfg_done   <= w_cfg_done_d;
      r_col_tag    <= w_col_tag_d;
      r_xfer_done  <= w_xfer_done_d;
      r_xfer_err   <= w_xfer_err_d;
      // Bus-facing strobes are decoded from next state so they leave a flop glitch-free.
      r_shift      <= (w_state_d == ST_SHIFT);
      r_scan_out   <= (w_state_d == ST_SHIFT) && w_shadow_d[SCAN_LEN-1];
      r_enable     <= (w_state_d == ST_XFER);
    end
  end

`ifdef GON_XBUS_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_d;
    end
  end
`endif

  assign cfg_busy    = r_shift;
  assign scan_en_id  = r_shift;
  assign scan_out_id = r_scan_out;
  assign cfg_done    = r_cfg_done;
  assign configured  = r_configured;
  assign req_ready   = w_req_ready;
  assign col_tag     = r_col_tag;
  assign enable_in   = r_enable;
  assign xfer_done   = r_xfer_done;
  assign xfer_err    = r_xfer_err;

endmodule
